// File: rtl/audio_clip_sequencer_pkg.sv
// Shared types for the audio clip sequencer: FSM state encoding, default
// widths, clip length and bank index types, plus state-class helpers.
package audio_seq_pkg;

  localparam int ADDR_W_DEF = 17;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REC_WAIT,
    S_REC_WRITE,
    S_PLAY_READ,
    S_PLAY_LAT,
    S_PLAY_OUT,
    S_PLAY_WAIT
  } seq_state_t;

  // Holds 0..MAX_SAMPLES, hence one bit wider than an address.
  typedef logic [ADDR_W_DEF:0] clip_len_t;
  typedef logic                bank_t;

  function automatic logic is_rec(input seq_state_t s);
    return (s == S_REC_WAIT) || (s == S_REC_WRITE);
  endfunction

  function automatic logic is_play(input seq_state_t s);
    return (s == S_PLAY_READ) || (s == S_PLAY_LAT) ||
           (s == S_PLAY_OUT)  || (s == S_PLAY_WAIT);
  endfunction

endpackage

// File: rtl/audio_clip_sequencer_if.sv
// Datapath/memory bundle between the sequencer (master) and the
// deserializer, serializer and clip banks (slave).
//
// Handshake: deser_done_i and ser_done_i are single-cycle pulses from the
// slave side; deser_done_i qualifies deser_data_i in that cycle. ser_enable_o
// is a single-cycle pulse qualifying ser_data_o. mem_en_o is a one-cycle
// access strobe; mem_we_o, mem_addr_o, mem_bank_o and mem_wdata_o are only
// meaningful while it is high. mem_rdata_i follows a read strobe by the
// block-RAM read latency.
interface audio_clip_sequencer_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16
);
  logic              deser_done_i;
  logic [DATA_W-1:0] deser_data_i;
  logic              deser_enable_o;
  logic              ser_done_i;
  logic              ser_enable_o;
  logic [DATA_W-1:0] ser_data_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_bank_o;
  logic              mem_en_o;
  logic              mem_we_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (
    input  deser_done_i, deser_data_i, ser_done_i, mem_rdata_i,
    output deser_enable_o, ser_enable_o, ser_data_o,
           mem_addr_o, mem_bank_o, mem_en_o, mem_we_o, mem_wdata_o
  );

  modport slave (
    output deser_done_i, deser_data_i, ser_done_i, mem_rdata_i,
    input  deser_enable_o, ser_enable_o, ser_data_o,
           mem_addr_o, mem_bank_o, mem_en_o, mem_we_o, mem_wdata_o
  );
endinterface

// File: rtl/audio_clip_sequencer_edge.sv
// Rising-edge detector for a synchronized button level. History resets to 1
// so a button held through reset produces no pulse; the pulse is registered.
module rise_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic level_i,
  output logic pulse_o
);
  logic hist_q, hist_d;
  logic pulse_q, pulse_d;

  // Next history and edge pulse from the current level.
  always_comb begin
    hist_d  = level_i;
    pulse_d = level_i & ~hist_q;
  end

  // History and pulse registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hist_q  <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;
endmodule

// File: rtl/audio_clip_sequencer.sv
// Record/playback sequencer for two clip banks. Owns the shared memory port
// and the per-bank recorded lengths.
// Build option: LOOP_PLAYBACK_EN makes playback wrap to address 0 at the end
// of the clip until aborted by a play edge.
module audio_clip_sequencer
  import audio_seq_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MAX_SAMPLES = 131072,
  parameter int RD_LAT      = 1
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   record_command_i,
  input  logic                   play_command_i,
  input  logic                   record_clip_select_i,
  input  logic                   play_clip_select_i,
  audio_clip_sequencer_if.master dp,
  output logic                   busy_o,
  output logic [1:0]             record_clip_o,
  output logic [1:0]             play_clip_o,
  output seq_state_t             state_dbg_o
);
  localparam logic [ADDR_W:0] MAX_LEN  = (ADDR_W+1)'(MAX_SAMPLES);
  localparam logic [1:0]      LAT_LAST = 2'(RD_LAT - 1);

  logic rec_edge, play_edge;

  rise_edge_detect u_rec_edge (
    .clk_i(clock_i), .rst_ni(reset_i),
    .level_i(record_command_i), .pulse_o(rec_edge)
  );

  rise_edge_detect u_play_edge (
    .clk_i(clock_i), .rst_ni(reset_i),
    .level_i(play_command_i), .pulse_o(play_edge)
  );

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  bank_t             bank_q, bank_d;
  logic [ADDR_W:0]   len_q [2];
  logic [ADDR_W:0]   len_d [2];
  logic [DATA_W-1:0] sample_q, sample_d;
  logic [DATA_W-1:0] ser_data_q, ser_data_d;
  logic [1:0]        lat_q, lat_d;
  logic              stop_q, stop_d;   // record edge seen during REC_WRITE
  logic [ADDR_W:0]   addr_inc;

  assign addr_inc = {1'b0, addr_q} + {{ADDR_W{1'b0}}, 1'b1};

  // Next-state and datapath updates; play edge aborts any playback state.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    bank_d     = bank_q;
    len_d      = len_q;
    sample_d   = sample_q;
    ser_data_d = ser_data_q;
    lat_d      = lat_q;
    stop_d     = stop_q;
    if (play_edge && is_play(state_q)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rec_edge) begin
            state_d = S_REC_WAIT;
            addr_d  = '0;
            bank_d  = record_clip_select_i;
            stop_d  = 1'b0;
          end else if (play_edge && (len_q[play_clip_select_i] != '0)) begin
            state_d = S_PLAY_READ;
            addr_d  = '0;
            bank_d  = play_clip_select_i;
          end
        end
        S_REC_WAIT: begin
          if (rec_edge || stop_q) begin
            len_d[bank_q] = {1'b0, addr_q};
            stop_d        = 1'b0;
            state_d       = S_IDLE;
          end else if (dp.deser_done_i) begin
            sample_d = dp.deser_data_i;
            state_d  = S_REC_WRITE;
          end
        end
        S_REC_WRITE: begin
          if (rec_edge) stop_d = 1'b1;
          if (addr_inc == MAX_LEN) begin
            len_d[bank_q] = MAX_LEN;
            stop_d        = 1'b0;
            state_d       = S_IDLE;
          end else begin
            addr_d  = addr_inc[ADDR_W-1:0];
            state_d = S_REC_WAIT;
          end
        end
        S_PLAY_READ: begin
          lat_d   = '0;
          state_d = S_PLAY_LAT;
        end
        S_PLAY_LAT: begin
          if (lat_q == LAT_LAST) begin
            ser_data_d = dp.mem_rdata_i;
            state_d    = S_PLAY_OUT;
          end else begin
            lat_d = lat_q + 2'd1;
          end
        end
        S_PLAY_OUT: state_d = S_PLAY_WAIT;
        S_PLAY_WAIT: begin
          if (dp.ser_done_i) begin
            if (addr_inc == len_q[bank_q]) begin
`ifdef LOOP_PLAYBACK_EN
              addr_d  = '0;
              state_d = S_PLAY_READ;
`else
              state_d = S_IDLE;
`endif
            end else begin
              addr_d  = addr_inc[ADDR_W-1:0];
              state_d = S_PLAY_READ;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      bank_q     <= 1'b0;
      len_q[0]   <= '0;
      len_q[1]   <= '0;
      sample_q   <= '0;
      ser_data_q <= '0;
      lat_q      <= '0;
      stop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      bank_q     <= bank_d;
      len_q      <= len_d;
      sample_q   <= sample_d;
      ser_data_q <= ser_data_d;
      lat_q      <= lat_d;
      stop_q     <= stop_d;
    end
  end

  logic in_rec, in_play;
  assign in_rec  = is_rec(state_q);
  assign in_play = is_play(state_q);

  assign dp.deser_enable_o = in_rec;
  assign dp.ser_enable_o   = (state_q == S_PLAY_OUT);
  assign dp.ser_data_o     = ser_data_q;
  assign dp.mem_addr_o     = addr_q;
  assign dp.mem_bank_o     = bank_q;
  assign dp.mem_en_o       = (state_q == S_REC_WRITE) || (state_q == S_PLAY_READ);
  assign dp.mem_we_o       = (state_q == S_REC_WRITE);
  assign dp.mem_wdata_o    = sample_q;
  assign busy_o            = (state_q != S_IDLE);
  assign record_clip_o     = {in_rec,  in_rec  ? bank_q : record_clip_select_i};
  assign play_clip_o       = {in_play, in_play ? bank_q : play_clip_select_i};
  assign state_dbg_o       = state_q;
endmodule

// File: tb/tb_audio_clip_sequencer.sv
// Bench for audio_clip_sequencer (small bank: MAX_SAMPLES=8, RD_LAT=2).
// Honours LOOP_PLAYBACK_EN when defined.
module tb_audio_clip_sequencer;
  import audio_seq_pkg::*;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 16;
  localparam int MAX_SAMPLES = 8;
  localparam int RD_LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic rec_cmd = 1'b0, play_cmd = 1'b0, rec_sel = 1'b0, play_sel = 1'b0;
  logic busy;
  logic [1:0] rec_led, play_led;
  seq_state_t state_dbg;

  audio_clip_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dp_if ();

  audio_clip_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_SAMPLES(MAX_SAMPLES), .RD_LAT(RD_LAT)
  ) dut (
    .clock_i(clk), .reset_i(rst_n),
    .record_command_i(rec_cmd), .play_command_i(play_cmd),
    .record_clip_select_i(rec_sel), .play_clip_select_i(play_sel),
    .dp(dp_if.master),
    .busy_o(busy), .record_clip_o(rec_led), .play_clip_o(play_led),
    .state_dbg_o(state_dbg)
  );

  // ---------------- block-RAM model (fed by DUT writes) ----------------
  logic [DATA_W-1:0] ram [2][8];
  logic [DATA_W-1:0] rd0, rd1;
  always @(posedge clk) begin
    if (dp_if.mem_en_o && dp_if.mem_we_o) ram[dp_if.mem_bank_o][dp_if.mem_addr_o[2:0]] <= dp_if.mem_wdata_o;
    if (dp_if.mem_en_o && !dp_if.mem_we_o) rd0 <= ram[dp_if.mem_bank_o][dp_if.mem_addr_o[2:0]];
    rd1 <= rd0;
  end
  assign dp_if.mem_rdata_i = rd1;

  // ---------------- behavioural reference model ----------------
  // mode: 0 idle, 1 recording, 2 playing. While playing, m_t is the cycle
  // index within one sample: 0 read, 1..RD_LAT latency, RD_LAT+1 output,
  // RD_LAT+2 waiting for the serializer.
  int m_mode, m_t, m_addr, m_bank;
  int m_len [2];
  bit m_writing, m_hold;
  bit m_prev_r, m_prev_p, m_pulse_r, m_pulse_p;
  logic [DATA_W-1:0] m_sample, m_ser;
  logic [DATA_W-1:0] m_mem [2][8];

  always @(posedge clk) begin
    bit re, pe;
    if (!rst_n) begin
      m_mode = 0; m_t = 0; m_addr = 0; m_bank = 0;
      m_len[0] = 0; m_len[1] = 0;
      m_writing = 0; m_hold = 0;
      m_prev_r = 1; m_prev_p = 1; m_pulse_r = 0; m_pulse_p = 0;
      m_sample = '0; m_ser = '0;
    end else begin
      re = m_pulse_r;
      pe = m_pulse_p;
      m_pulse_r = rec_cmd && !m_prev_r;  m_prev_r = rec_cmd;
      m_pulse_p = play_cmd && !m_prev_p; m_prev_p = play_cmd;
      if (m_mode == 0) begin
        if (re) begin
          m_mode = 1; m_writing = 0; m_addr = 0; m_bank = int'(rec_sel); m_hold = 0;
        end else if (pe && m_len[play_sel] != 0) begin
          m_mode = 2; m_t = 0; m_addr = 0; m_bank = int'(play_sel);
        end
      end else if (m_mode == 1) begin
        if (!m_writing) begin
          if (re || m_hold) begin
            m_len[m_bank] = m_addr; m_mode = 0; m_hold = 0;
          end else if (dp_if.deser_done_i) begin
            m_sample = dp_if.deser_data_i; m_writing = 1;
          end
        end else begin
          m_mem[m_bank][m_addr] = m_sample;
          if (re) m_hold = 1;
          if (m_addr + 1 == MAX_SAMPLES) begin
            m_len[m_bank] = MAX_SAMPLES; m_mode = 0; m_hold = 0;
          end else begin
            m_addr++; m_writing = 0;
          end
        end
      end else begin
        if (pe) m_mode = 0;
        else if (m_t == RD_LAT + 2) begin
          if (dp_if.ser_done_i) begin
            m_addr++;
            m_t = 0;
            if (m_addr == m_len[m_bank]) begin
`ifdef LOOP_PLAYBACK_EN
              m_addr = 0;
`else
              m_mode = 0;
`endif
            end
          end
        end else begin
          if (m_t == RD_LAT) m_ser = m_mem[m_bank][m_addr];
          m_t++;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0, n_err = 0;
  bit cmp_en = 0;
  int n_wr = 0, n_ser = 0, n_en = 0;
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] ser_got_q [$];
  int rd_addr_q [$];
  int ser_mode = 0;    // 0 quiet, 1 answer each ser_enable, 2 random pulses
  int ser_fixed = 0;   // 0 random answer delay, else fixed delay
  int ser_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic cycle_check();
    logic e_en, e_we, e_ser;
    e_en  = (m_mode == 1 && m_writing) || (m_mode == 2 && m_t == 0);
    e_we  = (m_mode == 1 && m_writing);
    e_ser = (m_mode == 2 && m_t == RD_LAT + 1);
    chk("busy", busy, m_mode != 0);
    chk("deser_enable", dp_if.deser_enable_o, m_mode == 1);
    chk("mem_en", dp_if.mem_en_o, e_en);
    chk("mem_we", dp_if.mem_we_o, e_we);
    chk("ser_enable", dp_if.ser_enable_o, e_ser);
    chk("record_led", rec_led, {m_mode == 1, (m_mode == 1) ? m_bank[0] : rec_sel});
    chk("play_led", play_led, {m_mode == 2, (m_mode == 2) ? m_bank[0] : play_sel});
    if (e_en) begin
      chk("mem_addr", dp_if.mem_addr_o, m_addr);
      chk("mem_bank", dp_if.mem_bank_o, m_bank);
    end
    if (e_we) chk("mem_wdata", dp_if.mem_wdata_o, m_sample);
    if (e_ser) chk("ser_data", dp_if.ser_data_o, m_ser);
    if (dp_if.mem_en_o) n_en++;
    if (dp_if.mem_en_o && dp_if.mem_we_o) n_wr++;
    if (dp_if.mem_en_o && !dp_if.mem_we_o) rd_addr_q.push_back(int'(dp_if.mem_addr_o));
    if (dp_if.ser_enable_o) begin
      n_ser++;
      ser_got_q.push_back(dp_if.ser_data_o);
    end
  endtask

  // One cycle: sample at the falling edge, check, then run the serializer stub.
  task automatic tick();
    @(negedge clk);
    if (cmp_en) cycle_check();
    if (ser_mode == 2) dp_if.ser_done_i = ($urandom_range(0, 3) == 0);
    else if (ser_mode == 1) begin
      dp_if.ser_done_i = 1'b0;
      if (ser_cnt > 0) begin
        ser_cnt--;
        if (ser_cnt == 0) dp_if.ser_done_i = 1'b1;
      end else if (dp_if.ser_enable_o) begin
        ser_cnt = (ser_fixed != 0) ? ser_fixed : int'($urandom_range(1, 4));
      end
    end else dp_if.ser_done_i = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- driver tasks ----------------
  task automatic press_rec();
    rec_cmd = 1'b1; ticks(2); rec_cmd = 1'b0;
  endtask

  task automatic press_play();
    play_cmd = 1'b1; ticks(2); play_cmd = 1'b0;
  endtask

  task automatic send_sample(input logic [DATA_W-1:0] d);
    ticks(int'($urandom_range(3, 5)));
    dp_if.deser_data_i = d;
    dp_if.deser_done_i = 1'b1;
    tick();
    dp_if.deser_done_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    while (busy && k < budget) begin tick(); k++; end
    chk(name, busy, 1'b0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", busy, 0);
    chk("rst_deser_en", dp_if.deser_enable_o, 0);
    chk("rst_ser_en", dp_if.ser_enable_o, 0);
    chk("rst_ser_data", dp_if.ser_data_o, 0);
    chk("rst_mem_en", dp_if.mem_en_o, 0);
    chk("rst_mem_we", dp_if.mem_we_o, 0);
    chk("rst_mem_addr", dp_if.mem_addr_o, 0);
    chk("rst_mem_bank", dp_if.mem_bank_o, 0);
    chk("rst_mem_wdata", dp_if.mem_wdata_o, 0);
    chk("rst_leds", {rec_led, play_led}, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int exp_addr [7];
    dp_if.deser_done_i = 1'b0;
    dp_if.deser_data_i = '0;
    dp_if.ser_done_i   = 1'b0;
    // Buttons held through reset must not trigger commands afterwards.
    rec_cmd = 1'b1; play_cmd = 1'b1;
    @(posedge clk);
    cmp_en = 1;
    ticks(3);
    check_reset_outputs();
    rst_n = 1'b1;
    ticks(4);
    chk("held_through_reset_idle", busy, 0);
    rec_cmd = 1'b0; play_cmd = 1'b0;
    ticks(2);

    // Record 5 samples into bank 0, stop with a second record press.
    rec_sel = 1'b0; n_wr = 0;
    press_rec();
    for (int i = 1; i <= 5; i++) send_sample(DATA_W'(i));
    ticks(2);
    press_rec();
    wait_idle(20, "rec_stop_idle");
    chk("rec5_writes", n_wr, 5);
    chk("rec5_len_model", m_len[0], 5);
    for (int i = 0; i < 5; i++) chk("rec5_ram", ram[0][i], i + 1);

    // Play bank 0.
    ser_mode = 1; n_ser = 0; ser_got_q.delete(); rd_addr_q.delete();
    play_sel = 1'b0;
    press_play();
`ifndef LOOP_PLAYBACK_EN
    wait_idle(300, "play_end_idle");
    chk("play5_count", n_ser, 5);
    chk("play5_reads", rd_addr_q.size(), 5);
    for (int i = 1; i <= 5; i++) exp_q.push_back(DATA_W'(i));
    while (exp_q.size() > 0 && ser_got_q.size() > 0)
      chk("play5_data", ser_got_q.pop_front(), exp_q.pop_front());
    chk("play5_data_left", exp_q.size(), 0);
    for (int i = 0; i < 5 && i < rd_addr_q.size(); i++) chk("play5_addr", rd_addr_q[i], i);
`else
    exp_addr = '{0, 1, 2, 3, 4, 0, 1};
    k = 0;
    while (n_ser < 7 && k < 400) begin tick(); k++; end
    chk("loop_seen_7", n_ser >= 7, 1);
    press_play();
    wait_idle(10, "loop_abort_idle");
    chk("loop_reads", rd_addr_q.size() >= 7, 1);
    for (int i = 0; i < 7 && i < rd_addr_q.size(); i++) chk("loop_addr", rd_addr_q[i], exp_addr[i]);
`endif
    ticks(3);

    // Play an empty bank: nothing happens.
    play_sel = 1'b1; n_en = 0;
    press_play();
    for (int i = 0; i < 6; i++) begin tick(); chk("empty_play_busy", busy, 0); end
    chk("empty_play_mem_en", n_en, 0);

    // Simultaneous record and play edges: record wins. Then overflow bank 1.
    rec_sel = 1'b1; play_sel = 1'b0;
    rec_cmd = 1'b1; play_cmd = 1'b1;
    ticks(2);
    rec_cmd = 1'b0; play_cmd = 1'b0;
    tick();
    chk("both_edges_rec_led", rec_led, 2'b11);
    chk("both_edges_play_led", play_led, 2'b00);
    n_wr = 0;
    for (int i = 0; i < 10; i++) send_sample(DATA_W'($urandom));
    wait_idle(50, "max_idle");
    chk("max_writes", n_wr, 8);
    chk("max_len_model", m_len[1], 8);
    chk("max_other_len_model", m_len[0], 5);

    // Abort playback of bank 1 while waiting on the 3rd sample; a record
    // press during playback is ignored.
    ser_fixed = 8; n_ser = 0; rd_addr_q.delete();
    play_sel = 1'b1; rec_sel = 1'b0;
    press_play();
    ticks(5);
    press_rec();
    k = 0;
    while (n_ser < 3 && k < 200) begin tick(); k++; end
    chk("abort_third_pulse", n_ser, 3);
    chk("abort_addr", rd_addr_q.size() > 0 ? rd_addr_q[rd_addr_q.size()-1] : -1, 2);
    press_play();
    tick();
    chk("abort_idle", busy, 0);
    ticks(15);
    chk("abort_no_more_ser", n_ser, 3);
    ser_fixed = 0;

    // Record edge arriving during REC_WRITE is held and stops in REC_WAIT.
    rec_sel = 1'b0; n_wr = 0;
    press_rec();
    send_sample(16'h00a1);
    send_sample(16'h00a2);
    ticks(4);
    dp_if.deser_data_i = 16'h00a3;
    dp_if.deser_done_i = 1'b1;
    rec_cmd = 1'b1;
    tick();
    dp_if.deser_done_i = 1'b0;
    tick();
    rec_cmd = 1'b0;
    wait_idle(20, "hold_stop_idle");
    chk("hold_writes", n_wr, 3);
    chk("hold_len_model", m_len[0], 3);
    chk("hold_ram2", ram[0][2], 16'h00a3);

    // Reset in the middle of a recording; a play press while recording is ignored.
    rec_sel = 1'b1;
    press_rec();
    send_sample(16'h1111);
    send_sample(16'h2222);
    press_play();
    ticks(2);
    rst_n = 1'b0; rec_sel = 1'b0; play_sel = 1'b0;
    ticks(2);
    check_reset_outputs();
    rst_n = 1'b1;
    tick();
    chk("rst_len0_model", m_len[0], 0);
    chk("rst_len1_model", m_len[1], 0);
    press_play();
    for (int i = 0; i < 5; i++) begin tick(); chk("post_rst_play_idle", busy, 0); end

`ifdef LOOP_PLAYBACK_EN
    // Loop a 3-sample clip: addresses 0,1,2,0,1 then abort.
    rec_sel = 1'b1;
    press_rec();
    for (int i = 0; i < 3; i++) send_sample(DATA_W'($urandom));
    ticks(2);
    press_rec();
    wait_idle(20, "loop3_rec_idle");
    rd_addr_q.delete(); play_sel = 1'b1;
    press_play();
    k = 0;
    while (rd_addr_q.size() < 5 && k < 300) begin tick(); k++; end
    press_play();
    wait_idle(30, "loop3_abort_idle");
    exp_addr = '{0, 1, 2, 0, 1, 0, 0};
    chk("loop3_reads", rd_addr_q.size() >= 5, 1);
    for (int i = 0; i < 5 && i < rd_addr_q.size(); i++) chk("loop3_addr", rd_addr_q[i], exp_addr[i]);
`endif

    // Randomized traffic against the model.
    ser_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 19) == 0) rec_cmd = ~rec_cmd;
      if ($urandom_range(0, 24) == 0) play_cmd = ~play_cmd;
      if ($urandom_range(0, 9) == 0) rec_sel = ~rec_sel;
      if ($urandom_range(0, 9) == 0) play_sel = ~play_sel;
      dp_if.deser_done_i = ($urandom_range(0, 3) == 0);
      dp_if.deser_data_i = DATA_W'($urandom);
    end
    dp_if.deser_done_i = 1'b0;
    rec_cmd = 1'b0; play_cmd = 1'b0;
    ticks(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
